// File: rtl/decoder_scan.sv
// decoder_scan: N-to-2**N registered decoder with a self-advancing scan mode.
// IDLE blanks the output, DECODE loads a one-hot from d through a valid/ready
// handshake, and SCAN walks the active bit across all outputs every SCAN_DIV cycles.
module decoder_scan #(
  parameter int unsigned N          = 3,
  parameter int unsigned SCAN_DIV   = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [N-1:0]          d,
  input  logic                  d_valid,
  output logic                  d_ready,
  output logic [(1 << N)-1:0]   y,
  output logic [N-1:0]          idx,
  output logic                  wrap
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PreMax = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StScan
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [N-1:0]    idx_inc;
  logic [PW-1:0]   pre_q, pre_d;
  // y_q is always kept active-high; polarity is applied only at the output.
  logic [W-1:0]    y_q, y_d;
  logic            wrap_q, wrap_d;
  // Set once a SCAN cycle has executed; clear means the next SCAN cycle is the first.
  logic            scan_run_q, scan_run_d;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
    logic [W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign idx_inc = idx_q + 1'b1;

  // Next-state: mode selects the following state; the current state decides the datapath.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pre_d      = pre_q;
    y_d        = y_q;
    wrap_d     = 1'b0;
    scan_run_d = scan_run_q;
    if (en) begin
      case (mode)
        2'b01:   state_d = StDecode;
        2'b10:   state_d = StScan;
        default: state_d = StIdle;
      endcase
      scan_run_d = (state_q == StScan);
      case (state_q)
        StDecode: begin
          pre_d = '0;
          if (d_valid) begin
            idx_d = d;
            y_d   = onehot(d);
          end else begin
            // Covers arriving from IDLE, where y was blanked.
            y_d = onehot(idx_q);
          end
        end
        StScan: begin
          if (!scan_run_q) begin
            y_d   = onehot(idx_q);
            pre_d = '0;
          end else if (pre_q == PreMax) begin
            pre_d  = '0;
            idx_d  = idx_inc;
            y_d    = onehot(idx_inc);
            wrap_d = (idx_q == '1);
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        default: begin
          y_d   = '0;
          pre_d = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset to a blank IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      pre_q      <= '0;
      y_q        <= '0;
      wrap_q     <= 1'b0;
      scan_run_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pre_q      <= pre_d;
      y_q        <= y_d;
      wrap_q     <= wrap_d;
      scan_run_q <= scan_run_d;
    end
  end

  // Outputs derive from registered state; en gates the handshake and the pulse.
  always_comb begin
    d_ready = en & (state_q == StDecode);
    y       = ACTIVE_LOW ? ~y_q : y_q;
    idx     = idx_q;
    wrap    = wrap_q & en;
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst, en, d_valid;
  logic [1:0] mode;
  logic [2:0] d;
  logic       rdy0, wrap0, rdy1, wrap1;
  logic [7:0] y0, y1;
  logic [2:0] idx0, idx1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    bit         dut;
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  decoder_scan #(.N(3), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .d_valid(d_valid),
    .d_ready(rdy0), .y(y0), .idx(idx0), .wrap(wrap0)
  );

  decoder_scan #(.N(3), .SCAN_DIV(1), .ACTIVE_LOW(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .d_valid(d_valid),
    .d_ready(rdy1), .y(y1), .idx(idx1), .wrap(wrap1)
  );

  // Monitor: drain every expectation queued since the last sample point.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [7:0] ay;
      logic [2:0] ai;
      logic       aw, ar;
      e  = sb.pop_front();
      ay = e.dut ? y1 : y0;
      ai = e.dut ? idx1 : idx0;
      aw = e.dut ? wrap1 : wrap0;
      ar = e.dut ? rdy1 : rdy0;
      n_tests++;
      if (ay !== e.y || ai !== e.idx || aw !== e.wrap || ar !== e.rdy) begin
        n_fail++;
        $display("FAIL %s: got y=%h idx=%0d wrap=%b rdy=%b, want y=%h idx=%0d wrap=%b rdy=%b",
                 e.name, ay, ai, aw, ar, e.y, e.idx, e.wrap, e.rdy);
      end
    end
  end

  task automatic push(input string nm, input bit dut, input logic [7:0] ey,
                      input logic [2:0] ei, input logic ew, input logic er);
    exp_t e;
    e.name = nm; e.dut = dut; e.y = ey; e.idx = ei; e.wrap = ew; e.rdy = er;
    sb.push_back(e);
  endtask

  // One clock edge with checking of u0 after it.
  task automatic step(input string nm, input logic [7:0] ey, input logic [2:0] ei,
                      input logic ew, input logic er);
    @(posedge clk);
    push(nm, 1'b0, ey, ei, ew, er);
    #1;
  endtask

  // One clock edge with checking of u1 after it.
  task automatic step1(input string nm, input logic [7:0] ey, input logic [2:0] ei,
                       input logic ew, input logic er);
    @(posedge clk);
    push(nm, 1'b1, ey, ei, ew, er);
    #1;
  endtask

  task automatic idle_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00; d = '0; d_valid = 1'b0;
    idle_edge();
    idle_edge();
    rst = 1'b0;
    step("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);

    // Decode sweep.
    mode = 2'b01;
    step("enter_decode", 8'h00, 3'd0, 1'b0, 1'b1);
    d_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 3'(i);
      step("decode_sweep", 8'h01 << i, 3'(i), 1'b0, 1'b1);
    end
    d_valid = 1'b0;
    step("decode_hold", 8'h80, 3'd7, 1'b0, 1'b1);

    // Transfer and switch to SCAN on the same edge, then scan through a wrap.
    d = 3'd5; d_valid = 1'b1; mode = 2'b10;
    step("mode_race", 8'h20, 3'd5, 1'b0, 1'b0);
    d_valid = 1'b0;
    for (int i = 0; i < 4; i++) step("scan_5", 8'h20, 3'd5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("scan_6", 8'h40, 3'd6, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("scan_7", 8'h80, 3'd7, 1'b0, 1'b0);
    step("scan_wrap", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("scan_0", 8'h01, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("scan_1", 8'h02, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("scan_2", 8'h04, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("scan_3", 8'h08, 3'd3, 1'b0, 1'b0);

    // Freeze at idx 3 with the prescaler at 2.
    en = 1'b0;
    for (int i = 0; i < 10; i++) step("freeze", 8'h08, 3'd3, 1'b0, 1'b0);
    en = 1'b1;
    step("unfreeze_1", 8'h08, 3'd3, 1'b0, 1'b0);
    step("unfreeze_2", 8'h10, 3'd4, 1'b0, 1'b0);

    // IDLE blanks y but keeps idx; DECODE then redisplays idx; reserved mode acts as IDLE.
    mode = 2'b00;
    step("to_idle", 8'h10, 3'd4, 1'b0, 1'b0);
    step("idle_blank", 8'h00, 3'd4, 1'b0, 1'b0);
    mode = 2'b01;
    step("idle_to_dec", 8'h00, 3'd4, 1'b0, 1'b1);
    step("dec_shows_idx", 8'h10, 3'd4, 1'b0, 1'b1);
    mode = 2'b11;
    step("reserved_1", 8'h10, 3'd4, 1'b0, 1'b0);
    step("reserved_2", 8'h00, 3'd4, 1'b0, 1'b0);

    // Asynchronous reset between edges.
    mode = 2'b01;
    step("pre_rst_dec", 8'h00, 3'd4, 1'b0, 1'b1);
    d = 3'd6; d_valid = 1'b1;
    step("pre_rst_xfer", 8'h40, 3'd6, 1'b0, 1'b1);
    d_valid = 1'b0;
    step("pre_rst_hold", 8'h40, 3'd6, 1'b0, 1'b1);
    idle_edge();
    rst = 1'b1;
    push("async_rst", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    push("async_rst_al", 1'b1, 8'hFF, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    mode = 2'b00;
    rst  = 1'b0;
    step("post_rst_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // Active-low, one step per cycle.
    mode = 2'b10;
    step1("al_enter", 8'hFF, 3'd0, 1'b0, 1'b0);
    step1("al_first", 8'hFE, 3'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      logic [7:0] oh;
      oh = 8'h01 << (k % 8);
      step1("al_scan", ~oh, 3'(k % 8), (k == 8), 1'b0);
    end
    mode = 2'b00;
    step1("al_leave", 8'hFD, 3'd1, 1'b0, 1'b0);
    step1("al_idle", 8'hFF, 3'd1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 The module SHALL have parameter N, default 3, meaning select width (legal range 1..8); output width W = 2**N.
REQ-002 The module SHALL have parameter SCAN_DIV, default 4, meaning clock cycles per scan step (legal range 1..65535).
REQ-003 The module SHALL have parameter ACTIVE_LOW, default 0, meaning 1 inverts every bit of y.
REQ-004 The module SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 The module SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 The module SHALL have port en  input  1  global enable; 0 freezes all state.
REQ-007 The module SHALL have port mode  input  2  00 IDLE, 01 DECODE, 10 SCAN, 11 reserved (treated as IDLE).
REQ-008 The module SHALL have port d  input  N  binary select for DECODE mode.
REQ-009 The module SHALL have port d_valid  input  1  d holds a valid select.
REQ-010 The module SHALL have port d_ready  output  1  block accepts d this cycle.
REQ-011 The module SHALL have port y  output  W  registered one-hot (or one-cold) decoded output.
REQ-012 The module SHALL have port idx  output  N  currently selected index.
REQ-013 The module SHALL have port wrap  output  1  one-cycle pulse when scan index wraps W-1 -> 0.

Function
REQ-014 The state register SHALL hold IDLE, DECODE or SCAN; each enabled cycle it loads the state named by mode (11 -> IDLE).
REQ-015 d_ready SHALL equal en AND (state == DECODE), combinationally from registered state only; mode changes affect d_ready one cycle later.
REQ-016 A transfer SHALL occur on a rising edge where d_valid AND d_ready; idx <= d and y <= onehot(d) on that edge (latency 1 cycle from transfer to y).
REQ-017 In DECODE without a transfer, idx and y SHALL hold.
REQ-018 In SCAN, a prescaler SHALL count 0..SCAN_DIV-1; on the edge where it equals SCAN_DIV-1 it clears, idx <= idx+1 modulo W, and y <= onehot(idx+1 mod W).
REQ-019 wrap SHALL be 1 for exactly the cycle after the edge where idx advances from W-1 to 0, else 0.
REQ-020 SCAN_DIV = 1 SHALL advance idx every enabled cycle in SCAN.
REQ-021 On the first cycle in SCAN (previous state not SCAN), y SHALL be loaded with onehot(idx) and the prescaler cleared; scanning resumes from the held idx.
REQ-022 In IDLE, y SHALL be all inactive; idx SHALL hold; prescaler SHALL clear.
REQ-023 Entering DECODE from SCAN or IDLE SHALL leave y showing onehot(idx) in DECODE until the next transfer.
REQ-024 en = 0 SHALL freeze state, idx, prescaler and y; wrap SHALL be 0; d_ready SHALL be 0.
REQ-025 Active bit value SHALL be 1 when ACTIVE_LOW = 0 and 0 when ACTIVE_LOW = 1; inactive bits the complement.
REQ-026 Exactly one bit of y SHALL be active in DECODE and SCAN states; zero bits in IDLE.
REQ-027 A mode change and a transfer in the same cycle SHALL complete the transfer (ready is from current state) and then switch state.

Reset
REQ-028 rst = 1 SHALL immediately, independent of clk, force state IDLE, idx 0, prescaler 0, wrap 0, d_ready 0, y all inactive (all 0s, or all 1s if ACTIVE_LOW).
REQ-029 Reset asserted mid-scan or mid-transfer SHALL discard the operation; after release the block stays IDLE until mode selects otherwise.

Verification (N=3, SCAN_DIV=4, ACTIVE_LOW=0 unless stated)
REQ-030 Reset: assert rst between clock edges -> y=8'h00, idx=0, d_ready=0, wrap=0 without a clock edge.
REQ-031 Decode sweep: mode=01, d_valid=1, d=0..7 one per cycle -> y=8'h01,02,04,...,80 one cycle after each transfer; idx tracks d.
REQ-032 Scan wrap: mode=10 from idx=6 -> y=8'h40 for 4 cycles, 8'h80 for 4, then 8'h01 with wrap=1 for exactly one cycle.
REQ-033 Freeze: en=0 for 10 cycles mid-scan at idx=3, prescaler=2 -> y=8'h08 held, d_ready=0; after en=1, advance to idx=4 after 2 more cycles.
REQ-034 Mode race: in DECODE, d=5 with d_valid=1 and mode=10 same cycle -> transfer taken (idx=5, y=8'h20), then scan resumes from 5.
REQ-035 ACTIVE_LOW=1, SCAN_DIV=1: mode=10 -> y=8'hFE,FD,FB,... one step per cycle; mode=00 -> y=8'hFF.
